// File: rtl/activation_collector.sv
// Gathers 16-bit activation lanes into 512-bit rows and writes them to a 2048-row result memory readable by the host.
// Define ACT_COLLECT_OVF_CNT_EN to add the saturating ovf_count output.
module activation_collector (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [4:0]   last_row,
    input  logic [10:0]  addr_start,
    input  logic [5:0]   batch,
    input  logic [511:0] activation_out,
    input  logic [31:0]  activation_out_valid,
    input  logic         s_ena,
    input  logic [16:0]  s_addra,
    output logic [31:0]  s_douta,
    output logic         busy,
    output logic         done,
`ifdef ACT_COLLECT_OVF_CNT_EN
    output logic [7:0]   ovf_count,
`endif
    output logic         ovf
);
    localparam int LANES  = 32;
    localparam int DATA_W = 16;
    localparam int ROW_W  = LANES * DATA_W;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t             state, state_next;
    logic [4:0]         last_row_q, row_cnt;
    logic [5:0]         batch_q, batch_cnt;
    logic [10:0]        wr_addr;
    logic [LANES-1:0]   flags, capture, drop;
    logic [ROW_W-1:0]   row_buf;
    logic [ROW_W-1:0]   mem [0:2047];
    logic               row_write, last_row_hit, last_batch_hit;
    logic [31:0]        rd_word_p1;
    logic               vld_p1;
    logic               addr_lsb_unused;

    assign addr_lsb_unused = ^s_addra[1:0];

`ifdef ACT_COLLECT_OVF_CNT_EN
    function automatic logic [5:0] lane_count(input logic [LANES-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) n = n + {5'd0, v[i]};
        return n;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [5:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {3'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction
`endif

    // A full flag set means the row is complete; the write happens the cycle after,
    // and lanes arriving in that cycle land in the freshly cleared flags.
    assign row_write      = (state == COLLECT) && (&flags);
    assign last_row_hit   = (row_cnt == last_row_q);
    assign last_batch_hit = (batch_cnt == batch_q);

    always_comb begin
        capture = '0;
        drop    = '0;
        if (state == COLLECT) begin
            if (row_write) begin
                capture = activation_out_valid;
            end else begin
                capture = activation_out_valid & ~flags;
                drop    = activation_out_valid & flags;
            end
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = COLLECT;
            end
            COLLECT: begin
                busy = 1'b1;
                if (row_write && last_row_hit && last_batch_hit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control stage: job state, counters, lane flags and overrun tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_row_q <= '0;
            batch_q    <= '0;
            wr_addr    <= '0;
            row_cnt    <= '0;
            batch_cnt  <= '0;
            flags      <= '0;
            ovf        <= 1'b0;
`ifdef ACT_COLLECT_OVF_CNT_EN
            ovf_count  <= '0;
`endif
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                last_row_q <= last_row;
                batch_q    <= batch;
                wr_addr    <= addr_start;
                row_cnt    <= '0;
                batch_cnt  <= '0;
                flags      <= '0;
                ovf        <= 1'b0;
`ifdef ACT_COLLECT_OVF_CNT_EN
                ovf_count  <= '0;
`endif
            end else if (state == COLLECT) begin
                flags <= row_write ? capture : (flags | capture);
                if (|drop) ovf <= 1'b1;
`ifdef ACT_COLLECT_OVF_CNT_EN
                ovf_count <= sat_add(ovf_count, lane_count(drop));
`endif
                if (row_write) begin
                    wr_addr <= wr_addr + 11'd1;
                    if (last_row_hit) begin
                        row_cnt   <= '0;
                        batch_cnt <= batch_cnt + 6'd1;
                    end else begin
                        row_cnt <= row_cnt + 5'd1;
                    end
                end
            end
        end
    end

    // Data stage: lane capture and row write, never reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (capture[i]) row_buf[i*DATA_W +: DATA_W] <= activation_out[i*DATA_W +: DATA_W];
        end
        if (row_write) mem[wr_addr] <= row_buf;
    end

    // Host read p1: word fetch (read-first against a same-cycle row write)
    always_ff @(posedge clk) begin
        if (s_ena) rd_word_p1 <= mem[s_addra[16:6]][{s_addra[5:2], 5'd0} +: 32];
    end

    // Host read p2: output register holds while no read is in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            s_douta <= '0;
        end else begin
            vld_p1 <= s_ena;
            if (vld_p1) s_douta <= rd_word_p1;
        end
    end
endmodule
